instdec_stage: RTL

//  Registered, parametrised RV32I decode stage with valid/ready handshake.

---
 rtl/instdec_stage.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/instdec_stage.sv
// RV32I decode stage with valid/ready handshake and a 2-entry skid buffer.
// Optional handoff statistics are enabled by defining INSTDEC_STATS_EN.
module instdec_stage #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst,
   input  logic [PC_W-1:0]   pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [6:0]        opcode,
   output logic [4:0]        rd,
   output logic [2:0]        func3,
   output logic [4:0]        rs1,
   output logic [4:0]        rs2,
   output logic [6:0]        func7,
   output logic [XLEN-1:0]   imm,
   output logic [2:0]        imm_fmt,
   output logic              illegal
`ifdef INSTDEC_STATS_EN
   ,
   output logic [CNT_W-1:0]  dec_count,
   output logic [CNT_W-1:0]  ill_count
`endif
);

   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_FENCE  = 7'h0F;
   localparam logic [6:0] OP_OPIMM  = 7'h13;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [2:0]      func3;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [6:0]      func7;
      logic [XLEN-1:0] imm;
      fmt_e            imm_fmt;
      logic            illegal;
   } dec_t;

   dec_t        dec;
   dec_t        out_q;
   dec_t        skid_q;
   state_e      state;
   state_e      state_nxt;
   logic        in_ready_q;
   logic        accept;
   logic        handoff;
   logic        load_out;
   logic        load_skid;
   logic        out_from_skid;
   logic [31:0] imm32;

   // Combinational decode of the incoming word; results are captured only on accept.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      imm32       = '0;
      dec.pc      = pc;
      dec.opcode  = inst[6:0];
      dec.rd      = inst[11:7];
      dec.func3   = inst[14:12];
      dec.rs1     = inst[19:15];
      dec.rs2     = inst[24:20];
      dec.func7   = inst[31:25];
      dec.imm_fmt = FMT_R;
      dec.illegal = 1'b0;
      case (inst[6:0])
         OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_FENCE: begin
            dec.imm_fmt = FMT_I;
            // Shift-immediates carry an unsigned shamt; func7 stays a plain field.
            if (inst[6:0] == OP_OPIMM && inst[13:12] == 2'b01)
               imm32 = {27'b0, inst[24:20]};
            else
               imm32 = {{20{inst[31]}}, inst[31:20]};
         end
         OP_STORE: begin
            dec.imm_fmt = FMT_S;
            imm32       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         OP_BRANCH: begin
            dec.imm_fmt = FMT_B;
            imm32       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dec.imm_fmt = FMT_U;
            imm32       = {inst[31:12], 12'b0};
         end
         OP_JAL: begin
            dec.imm_fmt = FMT_J;
            imm32       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OP_OP: begin
            dec.imm_fmt = FMT_R;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      dec.imm = XLEN'($signed(imm32));
   end

   assign accept    = in_valid & in_ready_q;
   assign handoff   = out_valid & out_ready;
   assign out_valid = (state != S_EMPTY);
   assign in_ready  = in_ready_q;

   // Occupancy control: flush overrides any accept or handoff in the same cycle.
   always_comb begin
      state_nxt     = state;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      if (flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept) begin
                  state_nxt = S_ONE;
                  load_out  = 1'b1;
               end
            end
            S_ONE: begin
               case ({accept, handoff})
                  2'b10: begin
                     state_nxt = S_TWO;
                     load_skid = 1'b1;
                  end
                  2'b11:   load_out  = 1'b1;
                  2'b01:   state_nxt = S_EMPTY;
                  default: state_nxt = S_ONE;
               endcase
            end
            S_TWO: begin
               if (handoff) begin
                  state_nxt     = S_ONE;
                  load_out      = 1'b1;
                  out_from_skid = 1'b1;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_EMPTY;
         in_ready_q <= 1'b1;
         // NOTE: the data entries are reset too, because every output must read 0 out of reset.
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         // NOTE: non-blocking updates so skid_q is read before it is overwritten in the same edge.
         state      <= state_nxt;
         in_ready_q <= (state_nxt != S_TWO);
         if (load_out)
            out_q <= out_from_skid ? skid_q : dec;
         if (load_skid)
            skid_q <= dec;
      end
   end

   assign out_pc  = out_q.pc;
   assign opcode  = out_q.opcode;
   assign rd      = out_q.rd;
   assign func3   = out_q.func3;
   assign rs1     = out_q.rs1;
   assign rs2     = out_q.rs2;
   assign func7   = out_q.func7;
   assign imm     = out_q.illegal ? '0 : out_q.imm;
   assign imm_fmt = out_q.illegal ? FMT_R : out_q.imm_fmt;
   assign illegal = out_q.illegal;

`ifdef INSTDEC_STATS_EN
   // Saturating handoff counters; a flushed cycle never counts as a handoff.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_count <= '0;
         ill_count <= '0;
      end else if (handoff && !flush) begin
         if (dec_count != {CNT_W{1'b1}})
            dec_count <= dec_count + 1'b1;
         if (out_q.illegal && ill_count != {CNT_W{1'b1}})
            ill_count <= ill_count + 1'b1;
      end
   end
`endif

endmodule
